// File: rtl/multi_edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// multi_edge_detect_pkg
//   Shared types and elaboration-time helpers for the multi-channel edge
//   detector.
//   - state_e       : global warm-up / run state of the detector
//   - sel_width()   : width of the counter readout select, never below 1
//   - wcnt_width()  : width of the warm-up counter for a given sync depth
// -----------------------------------------------------------------------------
package multi_edge_detect_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  function automatic int sel_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Warm-up counts 0..SYNC_STAGES, so it needs room for SYNC_STAGES+1 values.
  function automatic int wcnt_width(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/multi_edge_detect_edge_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
//   One detector channel: optional synchroniser, history register, registered
//   rise/fall pulses, sticky flags and a saturating edge counter.
//
//   Parameters: SYNC_STAGES (0 = input already synchronous), CNT_W.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     run               detection enabled (global FSM in RUN)
//     din               raw channel input
//     clr_rise/clr_fall clear the sticky flags (a same-edge set wins)
//     cnt_clr           clear the counter (a same-edge edge leaves it at 1)
//     rise_pulse/fall_pulse  one-cycle registered edge pulses
//     rise_flag/fall_flag    sticky edge flags
//     cnt               current counter value
// -----------------------------------------------------------------------------
module edge_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             din,
  input  logic             clr_rise,
  input  logic             clr_fall,
  input  logic             cnt_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             rise_flag,
  output logic             fall_flag,
  output logic [CNT_W-1:0] cnt
);

  logic s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic             hist_q, hist_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             rflag_q, rflag_d;
  logic             fflag_q, fflag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_edge;

  always_comb begin
    // History tracks the synchronised value even during warm-up so that the
    // first RUN comparison is against a settled value.
    hist_d   = s;
    rise_d   = run & s & ~hist_q;
    fall_d   = run & ~s & hist_q;
    any_edge = rise_d | fall_d;
    // Set dominates clear so an edge arriving with the clear is not lost.
    rflag_d  = rise_d | (rflag_q & ~clr_rise);
    fflag_d  = fall_d | (fflag_q & ~clr_fall);
    cnt_d    = cnt_q;
    if (cnt_clr) begin
      cnt_d = any_edge ? CNT_W'(1) : '0;
    end else if (any_edge && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      rflag_q <= 1'b0;
      fflag_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rflag_q <= rflag_d;
      fflag_q <= fflag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign rise_flag  = rflag_q;
  assign fall_flag  = fflag_q;
  assign cnt        = cnt_q;

endmodule

// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//   WIDTH-channel rise/fall detector with per-channel sticky flags and
//   saturating edge counters, plus a global warm-up FSM that keeps detection
//   off until the synchronisers and history registers hold real data.
//
//   Ports:
//     clk, rst                synchronous active-high reset
//     in[WIDTH]               monitored signals
//     rise_pulse/fall_pulse   one-cycle edge pulses
//     rise_flag/fall_flag     sticky edge flags, cleared by clr_rise/clr_fall
//     cnt_clr[WIDTH]          per-channel counter clear
//     cnt_sel, cnt_rd_data    registered counter readout (out-of-range reads 0)
//     ready                   detection live
//
//   Optional (macro MULTI_EDGE_DETECT_IRQ_EN):
//     rise_irq_en, fall_irq_en, irq  registered OR of enabled sticky flags
// -----------------------------------------------------------------------------
module multi_edge_detect
  import multi_edge_detect_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 8,
  localparam int SEL_W       = sel_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  input  logic [WIDTH-1:0] clr_rise,
  input  logic [WIDTH-1:0] clr_fall,
  input  logic [WIDTH-1:0] cnt_clr,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_rd_data,
  output logic             ready
`ifdef MULTI_EDGE_DETECT_IRQ_EN
  ,
  input  logic [WIDTH-1:0] rise_irq_en,
  input  logic [WIDTH-1:0] fall_irq_en,
  output logic             irq
`endif
);

  localparam int WCNT_W = wcnt_width(SYNC_STAGES);

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                ready_q;
  logic                run;

  // Warm-up lasts SYNC_STAGES+1 cycles after reset release: enough for the
  // sync chain to fill and the history register to capture its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARMUP;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        WARMUP: begin
          if (wcnt_q == WCNT_W'(SYNC_STAGES)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        RUN: begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= WARMUP;
          wcnt_q  <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign run   = (state_q == RUN);
  assign ready = ready_q;

  logic [CNT_W-1:0] cnt_arr [WIDTH];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      edge_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .din        (in[i]),
        .clr_rise   (clr_rise[i]),
        .clr_fall   (clr_fall[i]),
        .cnt_clr    (cnt_clr[i]),
        .rise_pulse (rise_pulse[i]),
        .fall_pulse (fall_pulse[i]),
        .rise_flag  (rise_flag[i]),
        .fall_flag  (fall_flag[i]),
        .cnt        (cnt_arr[i])
      );
    end
  endgenerate

  logic [CNT_W-1:0] cnt_rd_q, cnt_rd_d;

  // Loop compare rather than direct index so selects beyond WIDTH read 0.
  always_comb begin
    cnt_rd_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_rd_d = cnt_arr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_rd_q <= '0;
    else     cnt_rd_q <= cnt_rd_d;
  end

  assign cnt_rd_data = cnt_rd_q;

`ifdef MULTI_EDGE_DETECT_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |((rise_flag & rise_irq_en) | (fall_flag & fall_irq_en));
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_multi_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detect
//   Directed bench for multi_edge_detect with WIDTH=8, SYNC_STAGES=2, CNT_W=3.
//   Inputs change 1 time unit after a rising edge ("cycle t"); an input change
//   in cycle t shows up as a pulse after the rising edge of cycle t+3.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_edge_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] rise_pulse, fall_pulse, rise_flag, fall_flag;
  logic [7:0] clr_rise, clr_fall, cnt_clr;
  logic [2:0] cnt_sel;
  logic [2:0] cnt_rd;
  logic       ready;
`ifdef MULTI_EDGE_DETECT_IRQ_EN
  logic [7:0] rise_irq_en, fall_irq_en;
  logic       irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_edge_detect #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (din),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .rise_flag   (rise_flag),
    .fall_flag   (fall_flag),
    .clr_rise    (clr_rise),
    .clr_fall    (clr_fall),
    .cnt_clr     (cnt_clr),
    .cnt_sel     (cnt_sel),
    .cnt_rd_data (cnt_rd),
    .ready       (ready)
`ifdef MULTI_EDGE_DETECT_IRQ_EN
    ,
    .rise_irq_en (rise_irq_en),
    .fall_irq_en (fall_irq_en),
    .irq         (irq)
`endif
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, release, and wait out the 3-cycle warm-up.
  task automatic do_reset(input logic [7:0] init);
    din = init; clr_rise = '0; clr_fall = '0; cnt_clr = '0; cnt_sel = '0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic test_reset();
    din = 8'hFF; clr_rise = '0; clr_fall = '0; cnt_clr = '0; cnt_sel = '0;
`ifdef MULTI_EDGE_DETECT_IRQ_EN
    rise_irq_en = 8'hFF; fall_irq_en = 8'hFF;
`endif
    rst = 1'b1;
    cyc(2);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready); end
    n_checks++; if ((rise_pulse | fall_pulse) !== 8'h00) begin n_fail++; $display("FAIL rst_pulses got=%h/%h exp=00", rise_pulse, fall_pulse); end
    n_checks++; if ((rise_flag | fall_flag) !== 8'h00) begin n_fail++; $display("FAIL rst_flags got=%h/%h exp=00", rise_flag, fall_flag); end
    n_checks++; if (cnt_rd !== 3'd0) begin n_fail++; $display("FAIL rst_cnt_rd got=%0d exp=0", cnt_rd); end
`ifdef MULTI_EDGE_DETECT_IRQ_EN
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq); end
`endif
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      n_checks++; if (ready !== (k >= 3)) begin n_fail++; $display("FAIL warmup_ready k=%0d got=%b exp=%b", k, ready, (k >= 3)); end
      n_checks++; if ((rise_pulse | fall_pulse | rise_flag | fall_flag) !== 8'h00) begin
        n_fail++; $display("FAIL warmup_static k=%0d rp=%h fp=%h rf=%h ff=%h exp=00", k, rise_pulse, fall_pulse, rise_flag, fall_flag);
      end
    end
    n_checks++; if (cnt_rd !== 3'd0) begin n_fail++; $display("FAIL warmup_cnt got=%0d exp=0", cnt_rd); end
  endtask

  task automatic test_rise_fall();
    do_reset(8'h00);
    din[0] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      cyc(1);
      n_checks++; if (rise_pulse !== ((t == 3) ? 8'h01 : 8'h00)) begin n_fail++; $display("FAIL rf_rise t=%0d got=%h exp=%h", t, rise_pulse, (t == 3) ? 8'h01 : 8'h00); end
      n_checks++; if (fall_pulse !== 8'h00) begin n_fail++; $display("FAIL rf_nofall t=%0d got=%h exp=00", t, fall_pulse); end
      if (t == 3) begin
        n_checks++; if (rise_flag !== 8'h01) begin n_fail++; $display("FAIL rf_rflag got=%h exp=01", rise_flag); end
      end
      if (t == 4) begin
        n_checks++; if (cnt_rd !== 3'd1) begin n_fail++; $display("FAIL rf_cnt1 got=%0d exp=1", cnt_rd); end
      end
    end
    din[0] = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      cyc(1);
      n_checks++; if (fall_pulse !== ((t == 3) ? 8'h01 : 8'h00)) begin n_fail++; $display("FAIL rf_fall t=%0d got=%h exp=%h", t, fall_pulse, (t == 3) ? 8'h01 : 8'h00); end
      n_checks++; if (rise_pulse !== 8'h00) begin n_fail++; $display("FAIL rf_norise t=%0d got=%h exp=00", t, rise_pulse); end
      if (t == 3) begin
        n_checks++; if ({rise_flag, fall_flag} !== 16'h0101) begin n_fail++; $display("FAIL rf_flags got=%h/%h exp=01/01", rise_flag, fall_flag); end
      end
      if (t == 4) begin
        n_checks++; if (cnt_rd !== 3'd2) begin n_fail++; $display("FAIL rf_cnt2 got=%0d exp=2", cnt_rd); end
      end
    end
  endtask

  task automatic test_flag_clear();
    din[3] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      cyc(1);
      if (t == 2) clr_rise = 8'h08;
      if (t == 3) begin
        n_checks++; if (rise_pulse !== 8'h08) begin n_fail++; $display("FAIL fc_pulse got=%h exp=08", rise_pulse); end
        n_checks++; if (rise_flag !== 8'h09) begin n_fail++; $display("FAIL fc_set_wins got=%h exp=09", rise_flag); end
      end
      if (t == 4) begin
        n_checks++; if (rise_flag !== 8'h01) begin n_fail++; $display("FAIL fc_clear got=%h exp=01", rise_flag); end
        clr_rise = 8'h00;
      end
      if (t == 5) begin
        n_checks++; if (rise_flag !== 8'h01) begin n_fail++; $display("FAIL fc_hold got=%h exp=01", rise_flag); end
      end
    end
  endtask

  task automatic test_counter_sat();
    cnt_sel = 3'd5;
    for (int t = 0; t < 14; t++) begin
      if (t < 10) din[5] = ~din[5];
      cyc(1);
      if (t + 1 >= 3 && t + 1 <= 12) begin
        n_checks++; if ({rise_pulse[5], fall_pulse[5]} !== (((t - 2) % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL sat_alt tt=%0d got=%b%b exp=%b", t + 1, rise_pulse[5], fall_pulse[5], ((t - 2) % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      n_checks++; if ((rise_pulse & fall_pulse) !== 8'h00) begin n_fail++; $display("FAIL sat_excl tt=%0d got=%h exp=00", t + 1, rise_pulse & fall_pulse); end
      if (t + 1 == 6) begin
        n_checks++; if (cnt_rd !== 3'd3) begin n_fail++; $display("FAIL sat_cnt3 got=%0d exp=3", cnt_rd); end
      end
      if (t + 1 == 9) begin
        n_checks++; if (cnt_rd !== 3'd6) begin n_fail++; $display("FAIL sat_cnt6 got=%0d exp=6", cnt_rd); end
      end
    end
    n_checks++; if (cnt_rd !== 3'd7) begin n_fail++; $display("FAIL sat_cnt7 got=%0d exp=7", cnt_rd); end
    din[5] = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      cyc(1);
      if (t == 2) cnt_clr = 8'h20;
      if (t == 3) begin
        n_checks++; if (rise_pulse !== 8'h20) begin n_fail++; $display("FAIL clr_edge_pulse got=%h exp=20", rise_pulse); end
        cnt_clr = 8'h00;
      end
      if (t == 4) begin
        n_checks++; if (cnt_rd !== 3'd1) begin n_fail++; $display("FAIL clr_with_edge got=%0d exp=1", cnt_rd); end
        cnt_clr = 8'h20;
      end
      if (t == 5) cnt_clr = 8'h00;
      if (t == 6) begin
        n_checks++; if (cnt_rd !== 3'd0) begin n_fail++; $display("FAIL clr_alone got=%0d exp=0", cnt_rd); end
      end
    end
    cnt_sel = 3'd0;
    cyc(2);
    n_checks++; if (cnt_rd !== 3'd2) begin n_fail++; $display("FAIL sel_ch0 got=%0d exp=2", cnt_rd); end
  endtask

  task automatic test_all_channels();
    // Current levels: ch0=0, ch3=1, ch5=1 -> 8'h28; invert all at once.
    din = 8'hD7;
    for (int t = 1; t <= 4; t++) begin
      cyc(1);
      n_checks++; if (rise_pulse !== ((t == 3) ? 8'hD7 : 8'h00)) begin n_fail++; $display("FAIL all_rise t=%0d got=%h exp=%h", t, rise_pulse, (t == 3) ? 8'hD7 : 8'h00); end
      n_checks++; if (fall_pulse !== ((t == 3) ? 8'h28 : 8'h00)) begin n_fail++; $display("FAIL all_fall t=%0d got=%h exp=%h", t, fall_pulse, (t == 3) ? 8'h28 : 8'h00); end
    end
  endtask

  task automatic test_rst_midstream();
    for (int t = 0; t < 6; t++) begin
      din = ~din;
      cyc(1);
    end
    n_checks++; if ((rise_pulse | fall_pulse) !== 8'hFF) begin n_fail++; $display("FAIL mid_active got=%h exp=ff", rise_pulse | fall_pulse); end
    rst = 1'b1;
    din = ~din;
    cyc(1);
    n_checks++; if ({rise_pulse, fall_pulse, rise_flag, fall_flag} !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_clear rp=%h fp=%h rf=%h ff=%h exp=0", rise_pulse, fall_pulse, rise_flag, fall_flag);
    end
    n_checks++; if ({ready, cnt_rd} !== 4'h0) begin n_fail++; $display("FAIL mid_rst_ready_cnt got=%b/%0d exp=0/0", ready, cnt_rd); end
    din = ~din;
    cyc(1);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      n_checks++; if (ready !== (k >= 3)) begin n_fail++; $display("FAIL mid_warm_ready k=%0d got=%b exp=%b", k, ready, (k >= 3)); end
      n_checks++; if ((rise_pulse | fall_pulse | rise_flag | fall_flag) !== 8'h00) begin
        n_fail++; $display("FAIL mid_spurious k=%0d rp=%h fp=%h rf=%h ff=%h exp=00", k, rise_pulse, fall_pulse, rise_flag, fall_flag);
      end
    end
  endtask

`ifdef MULTI_EDGE_DETECT_IRQ_EN
  task automatic test_irq();
    rise_irq_en = 8'h00; fall_irq_en = 8'h02;
    do_reset(8'h02);
    din[1] = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      cyc(1);
      if (t == 3) begin
        n_checks++; if (fall_flag !== 8'h02) begin n_fail++; $display("FAIL irq_flag got=%h exp=02", fall_flag); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b exp=0", irq); end
      end
      if (t == 4) begin
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b exp=1", irq); end
        clr_fall = 8'h02;
      end
      if (t == 5) begin
        n_checks++; if ({fall_flag, irq} !== 9'h001) begin n_fail++; $display("FAIL irq_lag got=%h/%b exp=00/1", fall_flag, irq); end
        clr_fall = 8'h00;
      end
      if (t == 6) begin
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop got=%b exp=0", irq); end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; din = '0; clr_rise = '0; clr_fall = '0; cnt_clr = '0; cnt_sel = '0;
`ifdef MULTI_EDGE_DETECT_IRQ_EN
    rise_irq_en = '0; fall_irq_en = '0;
`endif
    test_reset();
    test_rise_fall();
    test_flag_clear();
    test_counter_sat();
    test_all_channels();
    test_rst_midstream();
`ifdef MULTI_EDGE_DETECT_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
